// File: rtl/alu_pkg.sv
// Shared types for the multi-cycle ALU: operation codes, FSM states, control width.
package alu_pkg;

    localparam int ALU_CTRL_WIDTH = 3;

    typedef enum logic [ALU_CTRL_WIDTH-1:0] {
        ALU_ADD  = 3'b000,
        ALU_SUB  = 3'b001,
        ALU_AND  = 3'b010,
        ALU_OR   = 3'b011,
        ALU_XOR  = 3'b100,
        ALU_SLT  = 3'b101,
        ALU_SLTU = 3'b110,
        ALU_MUL  = 3'b111
    } alu_op_t;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DONE
    } state_t;

endpackage

// File: rtl/alu_mul_iter.sv
// Shift-add multiplier datapath: one partial product per step, fixed DATA_WIDTH steps.
module alu_mul_iter
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic                  step,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic [DATA_WIDTH-1:0] acc_next,
    output logic                  last
);

    localparam int CNT_W = $clog2(DATA_WIDTH + 1);

    logic [DATA_WIDTH-1:0] mcand;
    logic [DATA_WIDTH-1:0] mplier;
    logic [DATA_WIDTH-1:0] acc;
    logic [CNT_W-1:0]      cnt;

    // acc_next is the accumulator after the current step; the top latches it on the last step
    always_comb begin
        acc_next = acc + (mplier[0] ? mcand : '0);
    end

    assign last = (cnt == CNT_W'(DATA_WIDTH - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
        end else if (load) begin
            mcand  <= a;
            mplier <= b;
            acc    <= '0;
            cnt    <= '0;
        end else if (step) begin
            acc    <= acc_next;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU with valid/ready handshakes; single-cycle ops finish in one cycle, MUL iterates.
module alu_mc
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [ALU_CTRL_WIDTH-1:0] ALUctrl,
    input  logic [DATA_WIDTH-1:0]     ALUop1,
    input  logic [DATA_WIDTH-1:0]     ALUop2,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_WIDTH-1:0]     ALUout,
    output logic                      EQ,
    output logic                      busy
);

    state_t                state;
    state_t                state_next;
    alu_op_t               op;
    logic [DATA_WIDTH-1:0] single_res;
    logic [DATA_WIDTH-1:0] mul_acc_next;
    logic                  mul_last;
    logic                  accept;
    logic                  mul_load;
    logic                  mul_step;

    assign op        = alu_op_t'(ALUctrl);
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state == MUL);
    assign accept    = in_ready && in_valid;
    assign mul_load  = accept && (op == ALU_MUL);
    assign mul_step  = (state == MUL);

    always_comb begin
        single_res = '0;
        case (op)
            ALU_ADD:  single_res = ALUop1 + ALUop2;
            ALU_SUB:  single_res = ALUop1 - ALUop2;
            ALU_AND:  single_res = ALUop1 & ALUop2;
            ALU_OR:   single_res = ALUop1 | ALUop2;
            ALU_XOR:  single_res = ALUop1 ^ ALUop2;
            ALU_SLT:  single_res = {{(DATA_WIDTH-1){1'b0}}, $signed(ALUop1) < $signed(ALUop2)};
            ALU_SLTU: single_res = {{(DATA_WIDTH-1){1'b0}}, ALUop1 < ALUop2};
            default:  single_res = '0;
        endcase
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (in_valid)  state_next = (op == ALU_MUL) ? MUL : DONE;
            MUL:  if (mul_last)  state_next = DONE;
            DONE: if (out_ready) state_next = IDLE;
            default:             state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            ALUout <= '0;
            EQ     <= 1'b0;
        end else begin
            state <= state_next;
            if (accept) begin
                EQ <= (ALUop1 == ALUop2);
                if (op != ALU_MUL) ALUout <= single_res;
            end
            if (mul_step && mul_last) ALUout <= mul_acc_next;
        end
    end

    alu_mul_iter #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_mul (
        .clk      (clk),
        .rst      (rst),
        .load     (mul_load),
        .step     (mul_step),
        .a        (ALUop1),
        .b        (ALUop2),
        .acc_next (mul_acc_next),
        .last     (mul_last)
    );

endmodule
